// File: rtl/ika2151_pkg.sv
// ika2151_pkg: shared register map, control-bit indices and FSM encodings for the OPM timer controller.
package ika2151_pkg;
  localparam logic [7:0] ADDR_TEST   = 8'h01;
  localparam logic [7:0] ADDR_CLKA1  = 8'h10;
  localparam logic [7:0] ADDR_CLKA2  = 8'h11;
  localparam logic [7:0] ADDR_CLKB   = 8'h12;
  localparam logic [7:0] ADDR_TMRCTL = 8'h14;
  localparam int BIT_RUNA   = 0;
  localparam int BIT_RUNB   = 1;
  localparam int BIT_IRQENA = 2;
  localparam int BIT_IRQENB = 3;
  localparam int BIT_FRSTA  = 4;
  localparam int BIT_FRSTB  = 5;
  localparam int BIT_CSM    = 7;
  typedef enum logic {B_IDLE, B_CNT} busy_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ARM, C_RUN} csm_state_t;
endpackage

// File: rtl/ika2151_busy_cnt.sv
// ika2151_busy_cnt: tick-gated down-counter with load and zero flag; saturates at zero.
module ika2151_busy_cnt
  import ika2151_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = !en ? cnt_q : load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/ika2151_timer_ctrl.sv
// ika2151_timer_ctrl: OPM timer register decode, flag-reset strobes, BUSY handshake and CSM key-on sequencer.
// Optional IKA2151_TIMER_CTRL_WRQUEUE_EN: holds one data write issued during BUSY and commits it once BUSY drops.
module ika2151_timer_ctrl
  import ika2151_pkg::*;
#(
  parameter int BUSY_TICKS = 64
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  input  logic       i_TIMERA_OVFL,
  output logic [7:0] o_CLKA1,
  output logic [1:0] o_CLKA2,
  output logic [7:0] o_CLKB,
  output logic       o_TIMERA_RUN,
  output logic       o_TIMERB_RUN,
  output logic       o_TIMERA_IRQ_EN,
  output logic       o_TIMERB_IRQ_EN,
  output logic       o_TIMERA_FRST,
  output logic       o_TIMERB_FRST,
  output logic [7:0] o_TEST,
  output logic       o_BUSY,
  output logic       o_CSM_KON,
  output logic [4:0] o_CSM_SLOT
);
  logic        tick, wr_req, wr_edge, data_wr, busy, busy_zero, we, hit_ctl, csm_clr, csm_on;
  logic [7:0]  wa, wd;
  logic        wr_prev_q, wr_prev_d, pend_q, pend_d;
  logic [7:0]  addr_q, addr_d, test_q, test_d, clka1_q, clka1_d, clkb_q, clkb_d;
  logic [1:0]  clka2_q, clka2_d, frst_q, frst_d;
  logic [4:0]  ctl_q, ctl_d, slot_q, slot_d;
  busy_state_t bst_q, bst_d;
  csm_state_t  cst_q, cst_d;
  assign tick    = ~i_phi1_NCEN_n;
  assign wr_req  = ~i_CS_n & ~i_WR_n;
  assign wr_edge = tick & wr_req & ~wr_prev_q;
  assign data_wr = wr_edge & i_A0;
  assign busy    = (bst_q == B_CNT);
`ifdef IKA2151_TIMER_CTRL_WRQUEUE_EN
  logic       hold_v_q, hold_v_d, commit;
  logic [7:0] hold_a_q, hold_a_d, hold_d_q, hold_d_d;
  assign commit = tick & ~busy & hold_v_q;
  assign we     = commit | (data_wr & ~busy);
  assign wa     = commit ? hold_a_q : addr_q;
  assign wd     = commit ? hold_d_q : i_D;
  always_comb begin
    hold_v_d = (data_wr & (busy | commit)) ? 1'b1 : commit ? 1'b0 : hold_v_q;
    hold_a_d = (data_wr & (busy | commit)) ? addr_q : hold_a_q;
    hold_d_d = (data_wr & (busy | commit)) ? i_D : hold_d_q;
  end
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n)
    if (!i_MRST_n) begin
      hold_v_q <= 1'b0;
      hold_a_q <= '0;
      hold_d_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_a_q <= hold_a_d;
      hold_d_q <= hold_d_d;
    end
`else
  assign we = data_wr & ~busy;
  assign wa = addr_q;
  assign wd = i_D;
`endif
  assign hit_ctl = we & (wa == ADDR_TMRCTL);
  assign csm_clr = hit_ctl & ~wd[BIT_CSM];
  assign csm_on  = ctl_q[4];
  ika2151_busy_cnt #(.W(8)) u_busy_cnt (
    .clk      (i_EMUCLK),
    .rst_n    (i_MRST_n),
    .en       (tick),
    .load     (we),
    .load_val (8'(BUSY_TICKS - 1)),
    .zero     (busy_zero)
  );
  always_comb begin
    wr_prev_d = tick ? wr_req : wr_prev_q;
    addr_d    = (wr_edge & ~i_A0) ? i_D : addr_q;
    test_d    = (we & (wa == ADDR_TEST)) ? wd : test_q;
    clka1_d   = (we & (wa == ADDR_CLKA1)) ? wd : clka1_q;
    clka2_d   = (we & (wa == ADDR_CLKA2)) ? wd[1:0] : clka2_q;
    clkb_d    = (we & (wa == ADDR_CLKB)) ? wd : clkb_q;
    ctl_d     = hit_ctl ? {wd[BIT_CSM], wd[BIT_IRQENB], wd[BIT_IRQENA], wd[BIT_RUNB], wd[BIT_RUNA]} : ctl_q;
    frst_d    = tick ? {hit_ctl & wd[BIT_FRSTB], hit_ctl & wd[BIT_FRSTA]} : frst_q;
    bst_d     = we ? B_CNT : (tick & busy & busy_zero) ? B_IDLE : bst_q;
  end
  // CSM sequencer; overflow is judged against the CSM bit as it stood before this tick's write
  always_comb begin
    cst_d  = cst_q;
    pend_d = pend_q;
    if (tick) begin
      if (csm_clr) begin
        cst_d  = C_IDLE;
        pend_d = 1'b0;
      end else begin
        case (cst_q)
          C_IDLE: cst_d = (i_TIMERA_OVFL & csm_on) ? C_ARM : C_IDLE;
          C_ARM:  cst_d = i_CYCLE_31 ? C_RUN : C_ARM;
          C_RUN: begin
            if (slot_q == 5'd31) begin
              cst_d  = (pend_q | (i_TIMERA_OVFL & csm_on)) ? C_ARM : C_IDLE;
              pend_d = 1'b0;
            end else begin
              pend_d = pend_q | (i_TIMERA_OVFL & csm_on);
            end
          end
          default: cst_d = C_IDLE;
        endcase
      end
    end
    slot_d = !tick ? slot_q : (cst_q == C_RUN && cst_d == C_RUN) ? slot_q + 5'd1 : 5'd0;
  end
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n)
    if (!i_MRST_n) begin
      wr_prev_q <= 1'b0;
      addr_q    <= '0;
      test_q    <= '0;
      clka1_q   <= '0;
      clka2_q   <= '0;
      clkb_q    <= '0;
      ctl_q     <= '0;
      frst_q    <= '0;
      bst_q     <= B_IDLE;
      cst_q     <= C_IDLE;
      pend_q    <= 1'b0;
      slot_q    <= '0;
    end else begin
      wr_prev_q <= wr_prev_d;
      addr_q    <= addr_d;
      test_q    <= test_d;
      clka1_q   <= clka1_d;
      clka2_q   <= clka2_d;
      clkb_q    <= clkb_d;
      ctl_q     <= ctl_d;
      frst_q    <= frst_d;
      bst_q     <= bst_d;
      cst_q     <= cst_d;
      pend_q    <= pend_d;
      slot_q    <= slot_d;
    end
  assign o_TEST          = test_q;
  assign o_CLKA1         = clka1_q;
  assign o_CLKA2         = clka2_q;
  assign o_CLKB          = clkb_q;
  assign o_TIMERA_RUN    = ctl_q[0];
  assign o_TIMERB_RUN    = ctl_q[1];
  assign o_TIMERA_IRQ_EN = ctl_q[2];
  assign o_TIMERB_IRQ_EN = ctl_q[3];
  assign o_TIMERA_FRST   = frst_q[0];
  assign o_TIMERB_FRST   = frst_q[1];
  assign o_BUSY          = busy;
  assign o_CSM_KON       = (cst_q == C_RUN);
  assign o_CSM_SLOT      = slot_q;
endmodule

// File: tb/tb_ika2151_timer_ctrl.sv
// tb_ika2151_timer_ctrl: randomized bench for ika2151_timer_ctrl against a tick-numbered behavioural model.
// The model tracks BUSY as an end tick and a CSM burst as its start tick; honours IKA2151_TIMER_CTRL_WRQUEUE_EN.
module tb_ika2151_timer_ctrl;
  localparam int N = 64;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, ncen_n = 1'b1, cyc31 = 1'b0, cs_n = 1'b1, wr_n = 1'b1, a0 = 1'b0, ovfl = 1'b0;
  logic [7:0] d = '0;
  logic [7:0] o_CLKA1, o_CLKB, o_TEST;
  logic [1:0] o_CLKA2;
  logic [4:0] o_CSM_SLOT;
  logic o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN, o_TIMERA_FRST, o_TIMERB_FRST, o_BUSY, o_CSM_KON;
  ika2151_timer_ctrl #(.BUSY_TICKS(N)) dut (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen_n), .i_CYCLE_31(cyc31),
    .i_CS_n(cs_n), .i_WR_n(wr_n), .i_A0(a0), .i_D(d), .i_TIMERA_OVFL(ovfl),
    .o_CLKA1(o_CLKA1), .o_CLKA2(o_CLKA2), .o_CLKB(o_CLKB),
    .o_TIMERA_RUN(o_TIMERA_RUN), .o_TIMERB_RUN(o_TIMERB_RUN),
    .o_TIMERA_IRQ_EN(o_TIMERA_IRQ_EN), .o_TIMERB_IRQ_EN(o_TIMERB_IRQ_EN),
    .o_TIMERA_FRST(o_TIMERA_FRST), .o_TIMERB_FRST(o_TIMERB_FRST),
    .o_TEST(o_TEST), .o_BUSY(o_BUSY), .o_CSM_KON(o_CSM_KON), .o_CSM_SLOT(o_CSM_SLOT)
  );
  int n_cmp = 0, n_bad = 0;
  int busy_hi, frsta_hi, frstb_hi, kon_hi;
  int tn = 0, busy_end = 0, run_start = -1;
  bit m_prev, armed, pend, m_clr, h_v;
  logic [7:0] m_addr, m_test, m_clka1, m_clkb, m_ctl, h_a, h_d;
  logic [1:0] m_clka2;
  logic m_frsta, m_frstb;
  wire [38:0] act = {o_CLKA1, o_CLKA2, o_CLKB, o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN,
                     o_TIMERA_FRST, o_TIMERB_FRST, o_TEST, o_BUSY, o_CSM_KON, o_CSM_SLOT};
  function automatic logic [38:0] exp_vec();
    logic k;
    k = run_start >= 0;
    return {m_clka1, m_clka2, m_clkb, m_ctl[0], m_ctl[1], m_ctl[2], m_ctl[3], m_frsta, m_frstb, m_test,
            1'(tn < busy_end), k, k ? 5'(tn - run_start) : 5'd0};
  endfunction
  task automatic m_reset();
    busy_end = 0; run_start = -1; armed = 0; pend = 0; m_prev = 0; h_v = 0;
    m_addr = 0; m_test = 0; m_clka1 = 0; m_clka2 = 0; m_clkb = 0; m_ctl = 0; m_frsta = 0; m_frstb = 0;
  endtask
  task automatic m_write(input logic [7:0] a, input logic [7:0] v);
    busy_end = tn + 1 + N;
    case (a)
      8'h01: m_test = v;
      8'h10: m_clka1 = v;
      8'h11: m_clka2 = v[1:0];
      8'h12: m_clkb = v;
      8'h14: begin m_ctl = v & 8'h8F; m_frsta = v[4]; m_frstb = v[5]; m_clr = !v[7]; end
      default: ;
    endcase
  endtask
  task automatic m_step();
    bit wr, pulse, busy_now, old, commit;
    wr = !cs_n && !wr_n;
    pulse = wr && !m_prev;
    m_prev = wr;
    busy_now = tn < busy_end;
    old = m_ctl[7];
    m_clr = 0; m_frsta = 0; m_frstb = 0; commit = 0;
`ifdef IKA2151_TIMER_CTRL_WRQUEUE_EN
    if (!busy_now && h_v) begin m_write(h_a, h_d); h_v = 0; commit = 1; end
`endif
    if (pulse && !a0) m_addr = d;
    if (pulse && a0) begin
`ifdef IKA2151_TIMER_CTRL_WRQUEUE_EN
      if (busy_now || commit) begin h_v = 1; h_a = m_addr; h_d = d; end
      else m_write(m_addr, d);
`else
      if (!busy_now) m_write(m_addr, d);
`endif
    end
    if (m_clr) begin
      armed = 0; run_start = -1; pend = 0;
    end else if (run_start >= 0) begin
      if (ovfl && old) pend = 1;
      if (tn - run_start == 31) begin run_start = -1; armed = pend; pend = 0; end
    end else if (armed) begin
      if (tn % 32 == 31) begin run_start = tn + 1; armed = 0; end
    end else if (ovfl && old) armed = 1;
    tn++;
  endtask
  task automatic step();
    cyc31 = (tn % 32) == 31;
    ncen_n = 0;
    @(posedge clk);
    m_step();
    #1 ncen_n = 1;
    busy_hi += int'(o_BUSY); frsta_hi += int'(o_TIMERA_FRST); frstb_hi += int'(o_TIMERB_FRST); kon_hi += int'(o_CSM_KON);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask
  task automatic bus_write(input logic a, input logic [7:0] v);
    a0 = a; d = v; cs_n = 0; wr_n = 0;
    repeat ($urandom_range(1, 3)) step();
    cs_n = 1; wr_n = 1;
    step();
  endtask
  task automatic wait_idle();
    while (tn < busy_end + 1) step();
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 m_reset();
    n_cmp++; if (act !== '0) begin n_bad++; $display("FAIL reset_state got %h want 0", act); end
    rst_n = 1;
    @(posedge clk); #1;
    bus_write(0, 8'h10); bus_write(1, 8'hA5);
    repeat (10) step();
    n_cmp++; if (act !== exp_vec()) begin n_bad++; $display("FAIL pre_reset got %h want %h", act, exp_vec()); end
    rst_n = 0;
    #1;
    n_cmp++; if ({o_BUSY, o_CLKA1} !== 9'h0) begin n_bad++; $display("FAIL async_reset busy/clka1 got %h want 0", {o_BUSY, o_CLKA1}); end
    m_reset();
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_regs();
    logic [7:0] as[5], vs[5];
    as = '{8'h10, 8'h11, 8'h12, 8'h01, 8'h13};
    vs = '{8'hFF, 8'h03, 8'h80, 8'($urandom), 8'($urandom)};
    for (int i = 0; i < 5; i++) begin
      bus_write(0, as[i]);
      busy_hi = 0;
      bus_write(1, vs[i]);
      while (tn < busy_end + 2) begin
        step();
        n_cmp++; if (o_BUSY !== 1'(tn < busy_end)) begin n_bad++; $display("FAIL busy_trace[%0d] got %b want %b", i, o_BUSY, tn < busy_end); end
      end
      n_cmp++; if (busy_hi !== N) begin n_bad++; $display("FAIL busy_len[%0d] got %0d want %0d", i, busy_hi, N); end
      n_cmp++; if (act !== exp_vec()) begin n_bad++; $display("FAIL reg_write[%0d] got %h want %h", i, act, exp_vec()); end
    end
    n_cmp++; if ({o_CLKA1, o_CLKA2, o_CLKB} !== {8'hFF, 2'b11, 8'h80}) begin
      n_bad++; $display("FAIL clk_regs got %h want %h", {o_CLKA1, o_CLKA2, o_CLKB}, {8'hFF, 2'b11, 8'h80});
    end
  endtask
  task automatic test_tmrctl();
    bus_write(0, 8'h14);
    frsta_hi = 0; frstb_hi = 0;
    a0 = 1; d = 8'h35; cs_n = 0; wr_n = 0;
    step();
    n_cmp++; if ({o_TIMERA_FRST, o_TIMERB_FRST} !== 2'b11) begin n_bad++; $display("FAIL frst_rise got %b want 11", {o_TIMERA_FRST, o_TIMERB_FRST}); end
    cs_n = 1; wr_n = 1;
    step();
    n_cmp++; if ({o_TIMERA_FRST, o_TIMERB_FRST} !== 2'b00) begin n_bad++; $display("FAIL frst_fall got %b want 00", {o_TIMERA_FRST, o_TIMERB_FRST}); end
    wait_idle();
    n_cmp++; if ({frsta_hi, frstb_hi} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL frst_len got %0d/%0d want 1/1", frsta_hi, frstb_hi); end
    n_cmp++; if ({o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN} !== 4'b1010) begin
      n_bad++; $display("FAIL ctl_bits got %b want 1010", {o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN});
    end
  endtask
  task automatic test_busy_drop();
    bus_write(0, 8'h12); bus_write(1, 8'h55);
    repeat (5) step();
    bus_write(1, 8'h11);
    n_cmp++; if (o_CLKB !== 8'h55) begin n_bad++; $display("FAIL busy_drop got %h want 55", o_CLKB); end
    wait_idle();
    repeat (3) step();
    wait_idle();
    n_cmp++; if (act !== exp_vec()) begin n_bad++; $display("FAIL after_busy_drop got %h want %h", act, exp_vec()); end
  endtask
  task automatic run_csm(input int ovfl_at_run_tick, input int want_kon, input string nm);
    bus_write(0, 8'h14); bus_write(1, 8'h80);
    wait_idle();
    while (tn % 32 != 10) step();
    ovfl = 1; step(); ovfl = 0;
    kon_hi = 0;
    for (int i = 0; i < 140; i++) begin
      ovfl = (run_start >= 0) && (tn - run_start == ovfl_at_run_tick);
      step();
      ovfl = 0;
      n_cmp++; if ({o_CSM_KON, o_CSM_SLOT} !== exp_vec()[5:0]) begin
        n_bad++; $display("FAIL %s_trace[%0d] kon/slot got %b/%0d want %b/%0d", nm, i, o_CSM_KON, o_CSM_SLOT, exp_vec()[5], exp_vec()[4:0]);
      end
    end
    n_cmp++; if (kon_hi !== want_kon) begin n_bad++; $display("FAIL %s_len got %0d want %0d", nm, kon_hi, want_kon); end
  endtask
  task automatic test_csm();
    run_csm(-1, 32, "csm");
  endtask
  task automatic test_csm_rearm();
    run_csm(5, 64, "csm_rearm");
  endtask
  task automatic test_csm_clear();
    int guard;
    guard = 0;
    ovfl = 1; step(); ovfl = 0;
    while (!(run_start >= 0 && tn - run_start == 8) && guard < 100) begin step(); guard++; end
    n_cmp++; if (o_CSM_KON !== 1'b1) begin n_bad++; $display("FAIL csm_clear_pre kon got %b want 1", o_CSM_KON); end
    a0 = 1; d = 8'h00; cs_n = 0; wr_n = 0;
    step();
    cs_n = 1; wr_n = 1;
    n_cmp++; if (o_CSM_KON !== 1'b0) begin n_bad++; $display("FAIL csm_clear kon got %b want 0", o_CSM_KON); end
    wait_idle();
  endtask
  task automatic test_random();
    int hold;
    logic [7:0] amap[6];
    amap = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h14, 8'h14};
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold > 0) hold--;
      else if (!cs_n) begin cs_n = 1; wr_n = 1; end
      else if ($urandom_range(0, 7) == 0) begin
        a0 = 1'($urandom);
        d = a0 ? 8'($urandom) : (($urandom_range(0, 7) == 0) ? 8'($urandom) : amap[$urandom_range(0, 5)]);
        cs_n = 0; wr_n = 0; hold = $urandom_range(0, 2);
      end
      ovfl = ($urandom_range(0, 19) == 0);
      step();
      n_cmp++; if (act !== exp_vec()) begin n_bad++; $display("FAIL random[%0d] got %h want %h", i, act, exp_vec()); end
    end
    ovfl = 0; cs_n = 1; wr_n = 1;
  endtask
  initial begin
    test_reset();
    test_regs();
    test_tmrctl();
    test_busy_drop();
    test_csm();
    test_csm_rearm();
    test_csm_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ika2151_timer_ctrl.md
Name: ika2151_timer_ctrl

Overview:
CPU-side controller that configures and sequences the timer block of the OPM core.
- Decodes the two-port bus (address latch / data write) into timer registers 0x01 (TEST), 0x10/0x11 (CLKA), 0x12 (CLKB) and 0x14 (CSM/flag-reset/IRQ-enable/load).
- Generates single-tick flag-reset strobes and the BUSY handshake.
- Runs the CSM key-on sequencer, triggered by timer A overflow.

Parameters:
BUSY_TICKS, 64, number of phi1 negative-edge enables BUSY stays high after a data write (valid 2..255).

Ports:
i_EMUCLK  in  1  emulator master clock
i_MRST_n  in  1  reset, asynchronous, active-low
i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable (low = tick); all state advances only on ticks
i_CYCLE_31  in  1  high during slot 31 of the 32-slot frame
i_CS_n  in  1  chip select, active-low
i_WR_n  in  1  write strobe, active-low
i_A0  in  1  0 = address port, 1 = data port
i_D  in  8  CPU write data
i_TIMERA_OVFL  in  1  timer A reload pulse, one tick wide
o_CLKA1  out  8  CLKA[9:2] (reg 0x10)
o_CLKA2  out  2  CLKA[1:0] (reg 0x11 bits 1:0)
o_CLKB  out  8  reg 0x12
o_TIMERA_RUN, o_TIMERB_RUN  out  1 each  reg 0x14 bits 0/1
o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN  out  1 each  reg 0x14 bits 2/3
o_TIMERA_FRST, o_TIMERB_FRST  out  1 each  flag-reset strobes
o_TEST  out  8  reg 0x01
o_BUSY  out  1  write-busy flag
o_CSM_KON  out  1  CSM key-on request to the envelope block
o_CSM_SLOT  out  5  slot index currently keyed by CSM

Behaviour:
- Reset (async, on i_MRST_n low): all register outputs 0; FRST strobes 0; o_BUSY 0; o_CSM_KON 0; o_CSM_SLOT 0; address latch 0; both FSMs to IDLE.
- Bus write:
  - A write is sampled on a tick where CS_n=0 and WR_n=0, with a rising-edge detect on (~CS_n & ~WR_n).
  - A held-low strobe counts as one write.
- A0=0: address latch <= i_D. Accepted regardless of BUSY.
- A0=1 with BUSY=0:
  - Decode the latched address.
  - Update the target register on the same tick; outputs are visible on the next tick.
  - Unmapped addresses are ignored for register purposes but still start BUSY.
- A0=1 with BUSY=1: write is dropped; no register change; BUSY counter is not restarted.
- Reg 0x14 bits:
  - 0 = RUNA, 1 = RUNB, 2 = IRQENA, 3 = IRQENB, 7 = CSM are stored.
  - Bits 4/5 (FRSTA/FRSTB) are not stored. Writing 1 produces a strobe on o_TIMERA_FRST / o_TIMERB_FRST exactly one tick long, starting the tick after the write.
- Busy FSM:
  - States: B_IDLE, B_CNT.
  - Accepted data write moves B_IDLE->B_CNT: counter loads BUSY_TICKS-1 and o_BUSY=1 from the next tick.
  - Counter decrements each tick. At 0 the FSM returns to B_IDLE and o_BUSY=0 on the following tick, so BUSY is high for exactly BUSY_TICKS ticks.
- CSM FSM:
  - States: C_IDLE, C_ARM, C_RUN.
  - C_IDLE->C_ARM on i_TIMERA_OVFL=1 with CSM=1.
  - C_ARM->C_RUN on the tick where i_CYCLE_31=1. o_CSM_SLOT resets to 0 for the first C_RUN tick.
  - In C_RUN: o_CSM_KON=1; o_CSM_SLOT increments each tick, wrapping 31->0. After 32 ticks (slot 31 emitted) the FSM goes to C_IDLE.
  - An overflow during C_ARM is absorbed.
  - An overflow during C_RUN sets a pending bit; after the frame ends the FSM goes to C_ARM instead of C_IDLE.
  - CSM cleared by write: any state -> C_IDLE next tick, and o_CSM_KON drops.
- Simultaneous events:
  - A write to 0x14 and an OVFL on the same tick: OVFL is evaluated against the old CSM value.
  - FRST strobe and an OVFL on the same tick are both emitted; the timer block resolves priority.

Optional Feature:
- Macro: IKA2151_TIMER_CTRL_WRQUEUE_EN.
- Defined: a 1-entry write holding register. A data write during BUSY is stored (address + data); a second write during BUSY overwrites it. The held write is committed on the tick BUSY falls and restarts BUSY.
- Undefined: writes during BUSY are dropped as above.

Decomposition:
- Shared package ika2151_pkg: register address constants (ADDR_TEST=8'h01, ADDR_CLKA1=8'h10, ADDR_CLKA2=8'h11, ADDR_CLKB=8'h12, ADDR_TMRCTL=8'h14), bit-index constants for 0x14, FSM state encodings for both FSMs.
- One sub-module: ika2151_busy_cnt (tick-gated down-counter with load and zero flag), reused by the bus FSM.

Test Plan:
- Reset mid-busy: write 0x10=0xA5, assert i_MRST_n low after 10 ticks -> o_BUSY=0 and o_CLKA1=0 immediately, without waiting for a clock.
- Write 0x10=0xFF, 0x11=0x03, 0x12=0x80 with BUSY gaps -> o_CLKA1=0xFF, o_CLKA2=2'b11, o_CLKB=0x80; each data write gives o_BUSY high for exactly 64 ticks.
- Write 0x14=0x35 -> RUNA=1, IRQENA=1, RUNB=0; o_TIMERA_FRST and o_TIMERB_FRST high for exactly 1 tick; a read-back of the stored bits shows 4/5 as 0.
- Data write 0x12=0x11 issued 5 ticks after a previous data write (BUSY=1) -> o_CLKB unchanged. With WRQUEUE_EN, o_CLKB=0x11 after BUSY falls, and BUSY is re-asserted for 64 ticks.
- CSM=1, OVFL pulse at slot 10 -> o_CSM_KON rises after the next i_CYCLE_31 and stays high for 32 ticks, with o_CSM_SLOT 0..31.
- A second OVFL at run tick 5 -> the frame re-arms and a second 32-tick burst follows. Writing 0x14=0x00 mid-run -> o_CSM_KON=0 the next tick.
